// File: rtl/mem_lsu.sv
// Load/store unit between EX and the register file: ALU results pass straight
// through, and loads/stores go to DataMem over a ce/ack handshake with a bus timeout.
module mem_lsu #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_mem,
    input  logic                  req_wr,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W-1:0]     req_alu_data,
    input  logic [REG_ADDR_W-1:0] req_rd_addr,
    input  logic                  req_rd_wr,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  mem_ce,
    output logic                  mem_wr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  stall,
    output logic                  exc_align,
    output logic                  exc_timeout
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF   = $clog2(NB);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                state, stateNxt;
    logic [CNT_W-1:0]      cnt;
    logic [1:0]            lSize;
    logic                  lSigned;
    logic [OFF-1:0]        lLane;
    logic [REG_ADDR_W-1:0] lRdAddr;
    logic                  lRdWr;

    logic [OFF-1:0]        lane;
    logic                  aligned, accept, alignErr, passThru, ackDone, toExp;
    logic [NB-1:0]         beNxt;
    logic [DATA_W-1:0]     wdNxt;
    logic [DATA_W-1:0]     shifted, sizeMask, loadData;
    logic                  signBit;

    assign lane      = req_addr[OFF-1:0];
    assign req_ready = (state == IDLE);
    assign stall     = !req_ready;

    always_comb begin
        aligned = 1'b0;
        case (req_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = !lane[0];
            2'b10:   aligned = (lane == '0);
            default: aligned = 1'b0;
        endcase
    end

    // Byte lanes and replicated store data, so DataMem never needs to shift.
    always_comb begin
        beNxt = '1;
        wdNxt = req_wdata;
        if (req_size == 2'b00) begin
            beNxt = NB'(1) << lane;
            for (int i = 0; i < NB; i++) wdNxt[8*i +: 8] = req_wdata[7:0];
        end else if (req_size == 2'b01) begin
            beNxt = NB'(2'b11) << lane;
            for (int i = 0; i < NB; i++) wdNxt[8*i +: 8] = req_wdata[8*(i%2) +: 8];
        end
    end

    always_comb begin
        shifted  = mem_rdata >> {lLane, 3'b000};
        sizeMask = '1;
        signBit  = 1'b0;
        case (lSize)
            2'b00: begin sizeMask = DATA_W'(8'hFF);    signBit = shifted[7];  end
            2'b01: begin sizeMask = DATA_W'(16'hFFFF); signBit = shifted[15]; end
            default: ;
        endcase
        loadData = (shifted & sizeMask) | ((lSigned && signBit) ? ~sizeMask : '0);
    end

    always_comb begin
        stateNxt = state;
        passThru = (state == IDLE) && req_valid && !req_mem;
        accept   = (state == IDLE) && req_valid && req_mem && aligned;
        alignErr = (state == IDLE) && req_valid && req_mem && !aligned;
        ackDone  = (state == ACCESS) && mem_ack;
        // Ack in the last allowed cycle takes priority over the timeout.
        toExp    = (state == ACCESS) && !mem_ack && (TIMEOUT != 0) && (cnt == CNT_LAST);
        case (state)
            IDLE:    if (accept) stateNxt = ACCESS;
            ACCESS:  if (ackDone || toExp) stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            lSize       <= '0;
            lSigned     <= 1'b0;
            lLane       <= '0;
            lRdAddr     <= '0;
            lRdWr       <= 1'b0;
            wb_we       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            mem_ce      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            exc_align   <= 1'b0;
            exc_timeout <= 1'b0;
        end else begin
            wb_we       <= 1'b0;
            exc_align   <= alignErr;
            exc_timeout <= toExp;
            if (passThru) begin
                wb_we   <= req_rd_wr;
                wb_addr <= req_rd_addr;
                wb_data <= req_alu_data;
            end
            if (accept) begin
                mem_ce    <= 1'b1;
                mem_wr    <= req_wr;
                mem_addr  <= {req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
                mem_be    <= beNxt;
                mem_wdata <= wdNxt;
                cnt       <= '0;
                lSize     <= req_size;
                lSigned   <= req_signed;
                lLane     <= lane;
                lRdAddr   <= req_rd_addr;
                lRdWr     <= req_rd_wr;
            end
            if (ackDone) begin
                mem_ce <= 1'b0;
                if (!mem_wr) begin
                    wb_we   <= lRdWr;
                    wb_addr <= lRdAddr;
                    wb_data <= loadData;
                end
            end else if (toExp) begin
                mem_ce <= 1'b0;
            end else if (state == ACCESS) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Parametrised successor to the single-cycle MEM stage. Sits between EX and RegFile.
- Passes ALU results through to write-back. Executes loads and stores against a variable-latency DataMem through a ce/ack handshake.
- Supports byte, half and word accesses with byte enables, and sign or zero extension on loads.
- Drives a stall to the upstream stages. Raises alignment and bus-timeout exceptions.

Parameters:
DATA_W, 32, data and register width; must be a multiple of 8 and at least 16.
ADDR_W, 32, memory address width.
REG_ADDR_W, 5, register-file address width.
TIMEOUT, 15, ACCESS cycles without ack before a bus error; 0 disables the timeout.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  EX presents an operation this cycle
req_ready  out  1  unit can accept; equals (state==IDLE)
req_mem  in  1  1 = memory op, 0 = ALU pass-through
req_wr  in  1  1 = store, 0 = load (valid when req_mem=1)
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  sign-extend load data
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data (right-aligned)
req_alu_data  in  DATA_W  pass-through result
req_rd_addr  in  REG_ADDR_W  destination register
req_rd_wr  in  1  destination write enable
wb_we  out  1  RegFile write strobe, one-cycle pulse
wb_addr  out  REG_ADDR_W  RegFile write address
wb_data  out  DATA_W  RegFile write data
mem_ce  out  1  DataMem chip enable
mem_wr  out  1  1 = write
mem_addr  out  ADDR_W  word-aligned address
mem_wdata  out  DATA_W  lane-replicated store data
mem_be  out  DATA_W/8  byte enables, little-endian
mem_rdata  in  DATA_W  read data
mem_ack  in  1  DataMem completion
stall  out  1  equals !req_ready
exc_align  out  1  misalignment pulse
exc_timeout  out  1  bus-timeout pulse

Behaviour:
- Reset (async, rst=1): state IDLE, counter 0, all outputs 0. mem_ce falls immediately even mid-ACCESS. The in-flight op is discarded with no write-back and no exception.
- All outputs are registered except req_ready and stall.
- NB = DATA_W/8; OFF = log2(NB); lane = req_addr[OFF-1:0].
- Alignment rules:
  - byte: always aligned.
  - half: lane[0] = 0.
  - word: lane = 0.
  - size 11: always misaligned.
- IDLE, req_valid=1, req_mem=0: next cycle wb_we=req_rd_wr, wb_addr=req_rd_addr, wb_data=req_alu_data. Latency 1, back-to-back every cycle.
- IDLE, req_valid=1, req_mem=1, misaligned: exc_align=1 for one cycle. No bus access, no write-back. Stay IDLE.
- IDLE, req_valid=1, req_mem=1, aligned: next cycle enter ACCESS with the following registered and held stable until exit:
  - mem_ce=1, mem_wr=req_wr.
  - mem_addr = req_addr with low OFF bits cleared.
  - mem_be:
    - byte: 1<<lane.
    - half: 2'b11<<lane.
    - word: all ones.
  - mem_wdata:
    - byte: replicated across all lanes.
    - half: replicated across all lanes.
    - word: as-is.
  - Counter cleared. Request fields latched.
- ACCESS, mem_ack=1:
  - Next cycle mem_ce=0 and state returns to IDLE.
  - Load: wb_we=latched rd_wr and wb_addr=latched rd_addr.
  - Load wb_data = (mem_rdata >> 8*lane), masked to the access size, then sign- or zero-extended per req_signed.
  - Store: no write-back.
- ACCESS, no ack: counter increments.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without ack, next cycle: exc_timeout=1 (one cycle), mem_ce=0, IDLE, no write-back.
  - Ack in the expiry cycle wins: normal completion, no exception.
- Minimum mem-op latency: accept edge → ACCESS → ack → wb_we. wb_we rises 2 cycles after acceptance with a same-cycle ack.
- mem_ack in IDLE is ignored. req_valid during ACCESS is ignored; EX must hold the request while stall=1.
- wb_we, exc_align and exc_timeout are mutually exclusive single-cycle pulses.

Test Plan:
- Pass-through: 3 back-to-back ALU ops (rd=1,2,3; data 0x11,0x22,0x33) → wb_we high 3 consecutive cycles with matching addr/data, stall never asserted.
- Signed byte load: addr 0x1003, size 00, signed=1, mem_rdata=0x80FF_FF7F, ack after 2 cycles → mem_addr 0x1000, mem_be 4'b1000, wb_data 0xFFFF_FF80, stall high 3 cycles.
- Half store: addr 0x2002, wdata 0x0000_BEEF → mem_be 4'b1100, mem_wdata 0xBEEF_BEEF, mem_wr=1, no wb_we after ack.
- Misaligned word load at 0x3001 → exc_align pulse next cycle, mem_ce stays 0, no wb_we.
- Timeout: TIMEOUT=4, word load, mem_ack held 0 → mem_ce high exactly 4 cycles, then exc_timeout pulse, req_ready=1. Repeat with ack in the 4th cycle → normal wb, no exception.
- rst asserted mid-ACCESS (no clock edge) → mem_ce and stall drop immediately. After release, no wb_we and no exception occur.
